// File: rtl/dt_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one Montgomery <-> regular domain-transfer unit
// among NUM_REQ requesters, with a watchdog on the unit's completion.
module dt_conv_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_to_mont,
    input  logic [NUM_REQ*W-1:0] req_px,
    input  logic [NUM_REQ*W-1:0] req_py,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [W-1:0]         prime,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_px,
    output logic [W-1:0]         rsp_py,
    output logic [W-1:0]         rsp_a,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 dt_in_sig,
    output logic                 dt_to_mont,
    output logic [W-1:0]         dt_px,
    output logic [W-1:0]         dt_py,
    output logic [W-1:0]         dt_a,
    output logic [W-1:0]         dt_prime,
    input  logic                 dt_done,
    input  logic [W-1:0]         dt_px_out,
    input  logic [W-1:0]         dt_py_out,
    input  logic [W-1:0]         dt_a_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_found_s;
    logic [TMR_W-1:0]   timer_r;
    logic               timeout_s;
    logic               err_r;
    logic               err_nxt_s;

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? (v - NUM_REQ) : v;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = {NUM_REQ{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? {IDX_W{1'b0}} : i + IDX_W'(1);
    endfunction

    // Round-robin pick: scanning backwards from rr_ptr+N-1 lets the lowest offset win last.
    always_comb begin
        win_found_s = |req;
        win_idx_s   = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            win_idx_s = req[wrap_idx(int'(rr_ptr_r) + k)] ?
                        IDX_W'(wrap_idx(int'(rr_ptr_r) + k)) : win_idx_s;
        end
    end

    // The watchdog counts cycles since ISSUE, so RESP lands exactly TIMEOUT cycles after it.
    assign timeout_s = (timer_r == TMR_W'(TIMEOUT - 1));

    // Next-state logic; a completion on the timeout cycle still wins.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (dt_done) begin
                    state_nxt_s = RESP;
                    err_nxt_s   = 1'b0;
                end else if (timeout_s) begin
                    state_nxt_s = RESP;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                err_nxt_s   = 1'b0;
            end
        endcase
    end

    // State register and outputs registered from the next state, so nothing is combinational from req.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            err_r     <= 1'b0;
            gnt       <= {NUM_REQ{1'b0}};
            rsp_valid <= {NUM_REQ{1'b0}};
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            dt_in_sig <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            err_r     <= err_nxt_s;
            gnt       <= (state_nxt_s == ISSUE) ? onehot(win_idx_s) : {NUM_REQ{1'b0}};
            rsp_valid <= (state_nxt_s == RESP) ? onehot(idx_r) : {NUM_REQ{1'b0}};
            rsp_err   <= (state_nxt_s == RESP) && err_nxt_s;
            busy      <= (state_nxt_s != IDLE);
            dt_in_sig <= (state_nxt_s == ISSUE);
        end
    end

    // Operand capture at grant, result capture on completion, pointer advance and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r   <= {IDX_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            timer_r    <= {TMR_W{1'b0}};
            dt_to_mont <= 1'b0;
            dt_px      <= {W{1'b0}};
            dt_py      <= {W{1'b0}};
            dt_a       <= {W{1'b0}};
            dt_prime   <= {W{1'b0}};
            rsp_px     <= {W{1'b0}};
            rsp_py     <= {W{1'b0}};
            rsp_a      <= {W{1'b0}};
        end else begin
            timer_r <= (state_r == IDLE) ? {TMR_W{1'b0}} : timer_r + TMR_W'(1);
            if ((state_r == IDLE) && win_found_s) begin
                idx_r      <= win_idx_s;
                dt_to_mont <= req_to_mont[win_idx_s];
                dt_px      <= req_px[int'(win_idx_s) * W +: W];
                dt_py      <= req_py[int'(win_idx_s) * W +: W];
                dt_a       <= req_a[int'(win_idx_s) * W +: W];
                dt_prime   <= prime;
            end
            if ((state_r == WAIT) && dt_done) begin
                rsp_px <= dt_px_out;
                rsp_py <= dt_py_out;
                rsp_a  <= dt_a_out;
            end
            if (state_r == RESP) begin
                rr_ptr_r <= next_idx(idx_r);
            end
        end
    end

endmodule

// File: tb/tb_dt_conv_arbiter.sv
// Bench for dt_conv_arbiter: behavioural transfer unit (with stub/spurious-done modes),
// directed scenarios, then randomized traffic against a transaction-level model.
module tb_dt_conv_arbiter;

    localparam int N       = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_to_mont, gnt, rsp_valid;
    logic [N*W-1:0] req_px, req_py, req_a;
    logic [W-1:0]   prime, rsp_px, rsp_py, rsp_a;
    logic           rsp_err, busy, dt_in_sig, dt_to_mont, dt_done;
    logic [W-1:0]   dt_px, dt_py, dt_a, dt_prime, dt_px_out, dt_py_out, dt_a_out;

    logic           u_done, spur_done, stub_mode;
    int             u_cnt;
    logic [W-1:0]   u_px, u_py, u_a;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             m_rr;
    logic [W-1:0]   m_px, m_py, m_a;
    int             got;
    int             cnt;

    always #5 clk = ~clk;

    dt_conv_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_to_mont(req_to_mont),
        .req_px(req_px), .req_py(req_py), .req_a(req_a), .prime(prime),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_px(rsp_px), .rsp_py(rsp_py), .rsp_a(rsp_a),
        .rsp_err(rsp_err), .busy(busy), .dt_in_sig(dt_in_sig), .dt_to_mont(dt_to_mont),
        .dt_px(dt_px), .dt_py(dt_py), .dt_a(dt_a), .dt_prime(dt_prime), .dt_done(dt_done),
        .dt_px_out(dt_px_out), .dt_py_out(dt_py_out), .dt_a_out(dt_a_out)
    );

    // x*2^32 mod p (to Montgomery) or x*2^-32 mod p (to regular, p odd)
    function automatic logic [31:0] conv(input logic [31:0] x, input logic [31:0] p, input logic to_m);
        logic [63:0] t;
        if (p == 32'd0) return 32'd0;
        if (to_m) begin
            t = {x, 32'd0} % {32'd0, p};
        end else begin
            t = {32'd0, x} % {32'd0, p};
            for (int s = 0; s < 32; s++) begin
                if (t[0]) t = t + {32'd0, p};
                t = t >> 1;
            end
        end
        return t[31:0];
    endfunction

    // Transfer unit: done one cycle per 32 shift/add steps after in_sig
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_cnt  <= 0;
            u_done <= 1'b0;
            u_px   <= 32'd0;
            u_py   <= 32'd0;
            u_a    <= 32'd0;
        end else begin
            u_done <= (u_cnt == 1);
            if (dt_in_sig && !stub_mode) begin
                u_cnt <= 32;
                u_px  <= conv(dt_px, dt_prime, dt_to_mont);
                u_py  <= conv(dt_py, dt_prime, dt_to_mont);
                u_a   <= conv(dt_a, dt_prime, dt_to_mont);
            end else if (u_cnt > 0) begin
                u_cnt <= u_cnt - 1;
            end
        end
    end
    assign dt_done   = u_done | spur_done;
    assign dt_px_out = u_px;
    assign dt_py_out = u_py;
    assign dt_a_out  = u_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] mont, input logic [31:0] px,
                           input logic [31:0] py, input logic [31:0] a);
        req[i]             = 1'b1;
        req_to_mont[i]     = mont[0];
        req_px[i*W +: W]   = px;
        req_py[i*W +: W]   = py;
        req_a[i*W +: W]    = a;
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_px = 32'd0;
        m_py = 32'd0;
        m_a  = 32'd0;
    endtask

    // Called in an IDLE cycle with req already driven; returns in the following IDLE cycle.
    task automatic serve(input int to_exp, input int keep, input int scramble, output int idx);
        logic [W-1:0] opx, opy, oa, op, epx, epy, ea;
        logic         omont;
        int           k;
        idx = -1;
        for (int n = N - 1; n >= 0; n--) begin
            if (req[(m_rr + n) % N]) idx = (m_rr + n) % N;
        end
        if (idx < 0) begin
            $display("FAIL serve_setup: no request pending");
            $fatal(1);
        end
        opx   = req_px[idx*W +: W];
        opy   = req_py[idx*W +: W];
        oa    = req_a[idx*W +: W];
        op    = prime;
        omont = req_to_mont[idx];
        epx   = to_exp != 0 ? m_px : conv(opx, op, omont);
        epy   = to_exp != 0 ? m_py : conv(opy, op, omont);
        ea    = to_exp != 0 ? m_a  : conv(oa, op, omont);
        tick();
        check("gnt", 64'(gnt), 64'(1) << idx);
        check("dt_in_sig", 64'(dt_in_sig), 64'd1);
        check("busy_issue", 64'(busy), 64'd1);
        check("dt_to_mont", 64'(dt_to_mont), 64'(omont));
        check("dt_px", 64'(dt_px), 64'(opx));
        check("dt_py", 64'(dt_py), 64'(opy));
        check("dt_a", 64'(dt_a), 64'(oa));
        check("dt_prime", 64'(dt_prime), 64'(op));
        if (keep == 0) req[idx] = 1'b0;
        if (scramble != 0) begin
            req_px[idx*W +: W] = $urandom;
            req_py[idx*W +: W] = $urandom;
            req_a[idx*W +: W]  = $urandom;
            prime              = $urandom | 32'd1;
        end
        k = 0;
        do begin
            tick();
            k++;
        end while (rsp_valid === 2'b00 && k < 200);
        check("latency", 64'(k), to_exp != 0 ? 64'(TIMEOUT) : 64'd34);
        check("rsp_valid", 64'(rsp_valid), 64'(1) << idx);
        check("rsp_err", 64'(rsp_err), 64'(to_exp != 0));
        check("rsp_px", 64'(rsp_px), 64'(epx));
        check("rsp_py", 64'(rsp_py), 64'(epy));
        check("rsp_a", 64'(rsp_a), 64'(ea));
        m_rr = (idx + 1) % N;
        m_px = epx;
        m_py = epy;
        m_a  = ea;
        tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_sig"}, 64'(dt_in_sig), 64'd0);
        check({tag, "_to_mont"}, 64'(dt_to_mont), 64'd0);
        check({tag, "_dt_ops"}, {dt_px, dt_prime}, 64'd0);
        check({tag, "_rsp_ops"}, {rsp_px, rsp_a}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req = '0; req_to_mont = '0; req_px = '0; req_py = '0; req_a = '0;
        prime = 32'd0; spur_done = 1'b0; stub_mode = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // single conversion to Montgomery
        prime = 32'd23;
        set_req(0, 32'd1, 32'd5, 32'd7, 32'd30);
        serve(0, 0, 0, got);
        check("t1_vals", {rsp_px, rsp_py}, {32'd14, 32'd15});
        check("t1_a", 64'(rsp_a), 64'd15);

        // round trip back to regular via requester 1
        set_req(1, 32'd0, 32'd14, 32'd15, 32'd15);
        serve(0, 0, 0, got);
        check("t2_vals", {rsp_px, rsp_py}, {32'd5, 32'd7});
        check("t2_a", 64'(rsp_a), 64'd7);

        // contention held from reset: grants alternate 0,1,0,1
        reset = 1'b0;
        set_req(0, 32'd1, 32'd3, 32'd4, 32'd5);
        set_req(1, 32'd0, 32'd9, 32'd10, 32'd11);
        tick();
        model_reset();
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            serve(0, 1, 0, got);
            check("t3_order", 64'(got), 64'(r % 2));
        end
        req = '0;
        tick();

        // watchdog: no completion, results kept, error flagged
        stub_mode = 1'b1;
        set_req(0, 32'd1, 32'd1, 32'd2, 32'd3);
        serve(1, 0, 0, got);
        stub_mode = 1'b0;
        set_req(1, 32'd1, 32'd8, 32'd9, 32'd10);
        serve(0, 0, 0, got);

        // reset mid-WAIT drops the transaction
        set_req(0, 32'd1, 32'd6, 32'd7, 32'd8);
        tick();
        check("t5_gnt", 64'(gnt), 64'd1);
        req = '0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check_all_zero("t5_reset");
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rsp_valid !== 2'b00) cnt++;
        end
        check("t5_no_rsp", 64'(cnt), 64'd0);
        set_req(1, 32'd1, 32'd12, 32'd13, 32'd14);
        serve(0, 0, 0, got);

        // spurious completion while idle
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("t6_rsp_valid2", 64'(rsp_valid), 64'd0);
        check("t6_rsp_kept", 64'(rsp_px), 64'(m_px));
        set_req(0, 32'd0, 32'd20, 32'd21, 32'd22);
        serve(0, 0, 0, got);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom, $urandom, $urandom, $urandom);
            end
            if (req == '0) set_req(int'($urandom_range(0, N - 1)), $urandom, $urandom, $urandom, $urandom);
            serve(0, int'($urandom_range(0, 1)), 1, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
